// File: rtl/ser_loader8_pkg.sv
// Shared definitions for the serial-to-parallel loader feeding the 8-bit enable register.
package ser_loader8_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LOAD  = 2'b10
  } state_t;

endpackage

// File: rtl/ser_loader8_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear, increment and terminal-count flag.
module ser_loader8_bit_cnt
  import ser_loader8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == LAST);

  // Wraps to zero on the terminal count so it never runs past WIDTH-1.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ser_loader8.sv
// Assembles a WIDTH-bit word from a serial stream and hands it to the downstream
// register with a one-cycle EN_Out strobe.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   ST_IDLE  | waiting for Start
//   ST_SHIFT | sampling Ser_In once per clock, WIDTH bits total
//   ST_LOAD  | word on Data_Out, EN_Out high for one cycle
module ser_loader8
  import ser_loader8_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             Start,
  input  logic             Ser_In,
  output logic [WIDTH-1:0] Data_Out,
  output logic             EN_Out,
  output logic             Busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_tc;

  ser_loader8_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_bit_cnt (
    .i_clk(clk),
    .i_res(res),
    .i_clr(w_cnt_clr),
    .i_inc(w_cnt_inc),
    .o_tc (w_tc)
  );

  assign w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], Ser_In}
                                 : {Ser_In, r_shift[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_cnt_inc   = 1'b1;
        w_state_nxt = w_tc ? ST_LOAD : ST_SHIFT;
      end
      ST_LOAD: begin
        // A Start here chains the next frame with no idle gap.
        if (Start) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_clr   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_SHIFT) begin
        r_shift <= w_shift_nxt;
        if (w_tc) begin
          r_data <= w_shift_nxt;
        end
      end
    end
  end

  assign Data_Out = r_data;
  assign EN_Out   = (r_state == ST_LOAD);
  assign Busy     = (r_state != ST_IDLE);

endmodule
